rv_mc_ctrl: RTL

- Multicycle RV32I main control FSM. Sits directly upstream of the ALU and drives its ALUop select and its operand-source muxes. Also drives all PC, IR, memory and register-file enables of the multicycle datapath.
- Consumes the IR contents and the ALU Zero flag. Handshakes with a variable-latency unified memory.

---
 rtl/rv_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_mc_ctrl.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/exec/mem/wb and drives datapath enables.
// Optional RV_MC_ILLEGAL_TRAP_EN adds a sticky 'illegal' output and a HALT trap on illegal instructions.
module rv_mc_ctrl #(
    parameter int unsigned ALUOP_W = 5,
    parameter int unsigned STATE_W = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [31:0]        ir,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         wd_sel,
    output logic               retire,
`ifdef RV_MC_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [STATE_W-1:0] state_o
);

    // ALU operation encoding shared with the ALU
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALUOP_SLL   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOP_SLT   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALUOP_XOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALUOP_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALUOP_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALUOP_AND   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALUOP_BNE   = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] ALUOP_BLT   = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] ALUOP_BGE   = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] ALUOP_BLTU  = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] ALUOP_BGEU  = ALUOP_W'(15);
    localparam logic [ALUOP_W-1:0] ALUOP_LUI   = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] ALUOP_AUIPC = ALUOP_W'(17);
    localparam logic [ALUOP_W-1:0] ALUOP_JALR  = ALUOP_W'(18);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = STATE_W'(0),
        ST_FETCH  = STATE_W'(1),
        ST_DECODE = STATE_W'(2),
        ST_EXEC   = STATE_W'(3),
        ST_MEM    = STATE_W'(4),
        ST_WB     = STATE_W'(5),
        ST_HALT   = STATE_W'(6)
    } state_t;

    state_t     state;
    state_t     state_n;
    logic       trap_c;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       opc_legal;
    logic       unused_ir_c;

    assign opcode      = ir[6:0];
    assign funct3      = ir[14:12];
    assign unused_ir_c = ^{ir[31], ir[29:15], ir[11:7]};
    assign state_o     = state;

    // funct3 -> ALU op for OP / OP-IMM; SUB only exists in the register form
    function automatic logic [ALUOP_W-1:0] arith_op(input logic [2:0] f3, input logic alt, input logic is_op);
        logic [ALUOP_W-1:0] op;
        case (f3)
            3'b000:  op = (alt && is_op) ? ALUOP_SUB : ALUOP_ADD;
            3'b001:  op = ALUOP_SLL;
            3'b010:  op = ALUOP_SLT;
            3'b011:  op = ALUOP_SLTU;
            3'b100:  op = ALUOP_XOR;
            3'b101:  op = alt ? ALUOP_SRA : ALUOP_SRL;
            3'b110:  op = ALUOP_OR;
            default: op = ALUOP_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        case (opcode)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opc_legal = 1'b1;
            default:                               opc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_RST;
        end else begin
            state <= state_n;
        end
    end

`ifdef RV_MC_ILLEGAL_TRAP_EN
    // Sticky trap flag; only reset clears it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            illegal <= 1'b0;
        end else if (trap_c) begin
            illegal <= 1'b1;
        end
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_n   = state;
        trap_c    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = ALUOP_ADD;
        reg_write = 1'b0;
        wd_sel    = 2'd0;
        retire    = 1'b0;

        case (state)
            ST_RST: state_n = ST_FETCH;

            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd2;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = ST_DECODE;
                end
            end

            // Precompute the PC-relative target into ALUOut
            ST_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                if (opc_legal) begin
                    state_n = ST_EXEC;
                end else begin
                    trap_c = 1'b1;
                end
            end

            ST_EXEC: begin
                case (opcode)
                    OPC_OP, OPC_OPIMM: begin
                        alu_src_a = 2'd1;
                        alu_src_b = (opcode == OPC_OP) ? 2'd0 : 2'd1;
                        alu_op    = arith_op(funct3, ir[30], opcode == OPC_OP);
                        state_n   = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        state_n   = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        if (funct3 == 3'b010 || funct3 == 3'b011) begin
                            trap_c = 1'b1;
                        end else begin
                            alu_src_a = 2'd1;
                            pc_write  = zero;
                            pc_src    = 2'd1;
                            retire    = 1'b1;
                            state_n   = ST_FETCH;
                            case (funct3)
                                3'b000:  alu_op = ALUOP_BEQ;
                                3'b001:  alu_op = ALUOP_BNE;
                                3'b100:  alu_op = ALUOP_BLT;
                                3'b101:  alu_op = ALUOP_BGE;
                                3'b110:  alu_op = ALUOP_BLTU;
                                default: alu_op = ALUOP_BGEU;
                            endcase
                        end
                    end
                    OPC_LUI: begin
                        alu_src_b = 2'd1;
                        alu_op    = ALUOP_LUI;
                        state_n   = ST_WB;
                    end
                    OPC_AUIPC: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                        alu_op    = ALUOP_AUIPC;
                        state_n   = ST_WB;
                    end
                    // rd takes the already-incremented PC on the same edge PC moves
                    OPC_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd1;
                        reg_write = 1'b1;
                        wd_sel    = 2'd2;
                        retire    = 1'b1;
                        state_n   = ST_FETCH;
                    end
                    OPC_JALR: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                        alu_op    = ALUOP_JALR;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        wd_sel    = 2'd2;
                        retire    = 1'b1;
                        state_n   = ST_FETCH;
                    end
                    default: trap_c = 1'b1;
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OPC_STORE);
                if (mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        retire  = 1'b1;
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_WB;
                    end
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                wd_sel    = (opcode == OPC_LOAD) ? 2'd1 : 2'd0;
                retire    = 1'b1;
                state_n   = ST_FETCH;
            end

            ST_HALT: state_n = ST_HALT;

            default: state_n = ST_RST;
        endcase

        // Illegal instruction: trap to HALT, or retire as a NOP
        if (trap_c) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
            state_n = ST_HALT;
`else
            retire   = 1'b1;
            pc_write = 1'b0;
            state_n  = ST_FETCH;
`endif
        end
    end

endmodule
